imem_loader: RTL and testbench

Boot-time writer for the 64-word instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives the instruction memory write port at consecutive word addresses from 0. Holds the MIPS core in reset until a complete image with a correct checksum has been written. Sits between the boot byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 49 ++++
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_WORD_W    = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEFAULT_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes MSB-first into 32-bit words; pulses word_valid_o the cycle after
// the fourth byte, with word_o held stable until the next word completes.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   byte_valid_i,
  input  logic [BYTE_W-1:0]      byte_i,
  output logic [1:0]             byte_idx_o,
  output logic                   word_valid_o,
  output logic [IMEM_WORD_W-1:0] word_o
);

  localparam int unsigned ASM_W = IMEM_WORD_W - BYTE_W;

  logic [1:0]             idx_q;
  logic [ASM_W-1:0]       asm_q;
  logic                   word_valid_q;
  logic [IMEM_WORD_W-1:0] word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= 2'd0;
      asm_q        <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      word_valid_q <= 1'b0;
      if (clr_i) begin
        idx_q <= 2'd0;
        asm_q <= '0;
      end else if (byte_valid_i) begin
        asm_q <= {asm_q[ASM_W-BYTE_W-1:0], byte_i};
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          word_q       <= {asm_q, byte_i};
          word_valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_idx_o   = idx_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header/data/checksum byte stream -> instruction memory writes,
// holding the core in reset until a checksum-verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [BYTE_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [ADDR_W-1:0]      wa,
  output logic [IMEM_WORD_W-1:0] wd,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state_q;
  logic                in_ready_q;
  logic [ADDR_W-1:0]   wa_q;
  logic                cpu_hold_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [BYTE_W-1:0]   csum_q;
  logic [CNT_W-1:0]    n_q;
  logic [CNT_W-1:0]    word_cnt_q;

  logic                   xfer;
  logic                   data_xfer;
  logic                   load_start;
  logic                   hdr_bad;
  logic                   last_word;
  logic                   csum_bad;
  logic [1:0]             byte_idx;
  logic                   word_valid;
  logic [IMEM_WORD_W-1:0] word;

  assign xfer       = in_valid && in_ready_q;
  assign data_xfer  = xfer && (state_q == ST_DATA);
  assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign hdr_bad    = (in_data == '0) || (32'(in_data) > DEPTH);
  assign last_word  = (word_cnt_q == (n_q - CNT_W'(1)));
  assign csum_bad   = (in_data != csum_q);

  imem_loader_byte_packer u_byte_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_i        (load_start),
    .byte_valid_i (data_xfer),
    .byte_i       (in_data),
    .byte_idx_o   (byte_idx),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      wa_q       <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csum_q     <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
    end else begin
      // Address advances once the write cycle for the current word is over.
      if (word_valid) begin
        wa_q <= wa_q + ADDR_W'(1);
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_HDR;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csum_q     <= '0;
            wa_q       <= '0;
            word_cnt_q <= '0;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_bad) begin
              state_q    <= ST_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              n_q     <= CNT_W'(in_data);
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum_q <= csum_q ^ in_data;
            if (byte_idx == 2'd3) begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
              if (last_word) begin
                state_q <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            state_q    <= ST_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= csum_bad;
            cpu_hold_q <= csum_bad;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = word_valid;
  assign wa       = wa_q;
  assign wd       = word;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and completion status are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_imem_loader;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [31:0]   wd;
  } wr_t;

  wr_t         exp_wr[$];
  logic [1:0]  exp_st[$];   // {err, cpu_hold} expected when done rises
  logic [31:0] img[$];
  int          checks = 0;
  int          errors = 0;
  logic        done_prev = 1'b0;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: pops one expected write per we pulse, one status per done rise.
  always @(negedge clk) begin
    wr_t        e;
    logic [1:0] s;
    if (we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wa=%0d wd=0x%08h expected no write", wa, wd);
      end else begin
        e = exp_wr.pop_front();
        chk_w("wr_addr", 32'(wa), 32'(e.wa));
        chk_w("wr_data", wd, e.wd);
      end
    end
    if (done === 1'b1 && done_prev === 1'b0) begin
      if (exp_st.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 err=%b expected no completion", err);
      end else begin
        s = exp_st.pop_front();
        chk_b("done_err", err, s[1]);
        chk_b("done_hold", cpu_hold, s[0]);
      end
    end
    done_prev = done;
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_image(input logic err_exp);
    wr_t e;
    foreach (img[i]) begin
      e.wa = AW'(i);
      e.wd = img[i];
      exp_wr.push_back(e);
    end
    exp_st.push_back({err_exp, err_exp});
  endtask

  function automatic logic [7:0] img_csum();
    logic [7:0] c = 8'h00;
    foreach (img[i]) c = c ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return c;
  endfunction

  task automatic load_image(input logic [7:0] hdr, input logic [7:0] cs, input bit stall);
    logic [31:0] w;
    send_byte(hdr, stall);
    foreach (img[i]) begin
      w = img[i];
      send_byte(w[31:24], stall);
      send_byte(w[23:16], stall);
      send_byte(w[15:8], stall);
      send_byte(w[7:0], stall);
    end
    send_byte(cs, stall);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 50 && done !== 1'b1; n++) @(negedge clk);
    chk_b("wait_done", done, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, "_in_ready"}, in_ready, 1'b0);
    chk_b({tag, "_we"}, we, 1'b0);
    chk_w({tag, "_wa"}, 32'(wa), 32'd0);
    chk_w({tag, "_wd"}, wd, 32'd0);
    chk_b({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    wr_t e;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Good 2-word image
    img = '{32'h20080005, 32'h00000000};
    expect_image(1'b0);
    pulse_start();
    chk_b("t1_busy", busy, 1'b1);
    chk_b("t1_in_ready", in_ready, 1'b1);
    chk_b("t1_hold", cpu_hold, 1'b1);
    load_image(8'd2, 8'h2D, 1'b0);
    wait_done();
    chk_b("t1_err", err, 1'b0);
    chk_b("t1_hold_low", cpu_hold, 1'b0);
    chk_b("t1_busy_low", busy, 1'b0);
    chk_b("t1_in_ready_low", in_ready, 1'b0);

    // Same image, wrong checksum
    expect_image(1'b1);
    pulse_start();
    chk_b("t2_done_clr", done, 1'b0);
    load_image(8'd2, 8'h2C, 1'b0);
    wait_done();
    chk_b("t2_err", err, 1'b1);
    chk_b("t2_hold", cpu_hold, 1'b1);

    // Illegal headers: 0 and 65
    img.delete();
    exp_st.push_back(2'b11);
    pulse_start();
    chk_b("t3_err_clr", err, 1'b0);
    chk_b("t3_done_clr", done, 1'b0);
    send_byte(8'h00, 1'b0);
    chk_b("t3_done", done, 1'b1);
    chk_b("t3_err", err, 1'b1);
    chk_b("t3_hold", cpu_hold, 1'b1);
    exp_st.push_back(2'b11);
    pulse_start();
    send_byte(8'h41, 1'b0);
    chk_b("t4_done", done, 1'b1);
    chk_b("t4_err", err, 1'b1);
    chk_b("t4_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);

    // Full 64-word image with random stalls
    img.delete();
    for (int i = 0; i < 64; i++)
      img.push_back({8'(i), 8'hA0 ^ 8'(i), 8'(i * 7), ~8'(i)});
    expect_image(1'b0);
    pulse_start();
    load_image(8'd64, img_csum(), 1'b1);
    wait_done();
    chk_b("t5_err", err, 1'b0);
    chk_b("t5_hold", cpu_hold, 1'b0);

    // Reset after 6 data bytes of N=3: only word 0 is written
    e.wa = AW'(0);
    e.wd = 32'h01020304;
    exp_wr.push_back(e);
    pulse_start();
    send_byte(8'd3, 1'b0);
    for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("abort");
    chk_w("abort_queue", 32'(exp_wr.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    img = '{32'hDEADBEEF};
    expect_image(1'b0);
    pulse_start();
    load_image(8'd1, 8'h22, 1'b0);
    wait_done();
    chk_b("t6_err", err, 1'b0);
    chk_b("t6_hold", cpu_hold, 1'b0);

    // Stray start during DATA is ignored
    img = '{32'h11223344, 32'hA5A5A5A5};
    expect_image(1'b0);
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    pulse_start();
    chk_b("t7_busy", busy, 1'b1);
    chk_b("t7_in_ready", in_ready, 1'b1);
    send_byte(8'h44, 1'b0);
    repeat (4) send_byte(8'hA5, 1'b0);
    send_byte(8'h44, 1'b0);
    wait_done();
    chk_b("t7_err", err, 1'b0);

    // Reload from DONE
    pulse_start();
    chk_b("t8_done_clr", done, 1'b0);
    chk_b("t8_busy", busy, 1'b1);
    chk_b("t8_hold", cpu_hold, 1'b1);
    img = '{32'h00000001};
    expect_image(1'b0);
    load_image(8'd1, 8'h01, 1'b0);
    wait_done();
    chk_b("t8_err", err, 1'b0);
    chk_b("t8_hold_low", cpu_hold, 1'b0);

    repeat (3) @(negedge clk);
    chk_w("writes_drained", 32'(exp_wr.size()), 32'd0);
    chk_w("status_drained", 32'(exp_st.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
